mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
// - Consumer side of the EX/MEM pipeline register: takes the held EX/MEM outputs and runs the data-memory access.
// - Uses a req/ack handshake to dmem. Stalls the upstream pipeline while an access is in flight.
// - Registers the MEM/WB stage outputs. A bubble is inserted while stalled.
// PARAMETERS
// - TIMEOUT_CYC  default 255  max ACCESS cycles waiting for dm_ack before bus error (1..255)
// PORTS
// - clk              in   1   rising-edge clock
// - rst              in   1   asynchronous reset, active-low
// - in_memRead       in   1   EX/MEM load flag
// - in_memWrite      in   1   EX/MEM store flag
// - in_memToReg      in   2   EX/MEM writeback select, passed through
// - in_regWrite      in   1   EX/MEM register write enable
// - in_aluResult     in   32  effective address / ALU result
// - in_readData2     in   32  store data
// - in_writeDataReg  in   5   destination register
// - in_fourPC        in   30  PC+4 [31:2]
// - dm_req           out  1   dmem request (held until ack or timeout)
// - dm_we            out  1   dmem write strobe, valid with dm_req
// - dm_addr          out  32  {in_aluResult[31:2],2'b00}
// - dm_wdata         out  32  in_readData2
// - dm_ack           in   1   dmem acknowledge, one cycle
// - dm_rdata         in   32  read data, valid with dm_ack
// - stall            out  1   combinational; holds PC, IF/ID, ID/EX, EX/MEM
// - out_regWrite, out_memToReg[2], out_aluResult[32], out_writeDataReg[5], out_fourPC[30]  out  MEM/WB copies
// - out_memData      out  32  captured load data
// - bus_err          out  1   one-cycle pulse on timeout
// - misalign_err     out  1   one-cycle pulse on misaligned access (0 without macro)
// BEHAVIOUR
// - Reset: state=IDLE, counter=0, rdata buffer=0. All registered outputs are 0; dm_req=0 and stall=0 immediately (async).
// - FSM states:
//   - IDLE: access = in_memRead|in_memWrite. If access, stall=1 and next state is ACCESS; else stall=0 and the WB registers load in_* (1-cycle pass-through).
//   - ACCESS: dm_req=1, stall=1, counter+1 per cycle.
//     - dm_ack: capture dm_rdata, go to DONE.
//     - counter==TIMEOUT_CYC-1 with no ack: set timeout flag, go to DONE.
//   - DONE: stall=0. WB registers load in_* (EX/MEM is still holding this instruction). out_memData = captured data. Go to IDLE; counter cleared.
// - Timeout in DONE: out_memData=0, out_regWrite forced 0, bus_err=1 for that cycle.
// - Any stall=1 edge: WB registers load a bubble (regWrite=0, memToReg=0, others 0). No double writeback.
// - Access latency (IDLE->DONE): ack in the k-th ACCESS cycle gives stall high k+1 cycles; the WB load happens on the DONE edge.
// - memRead & memWrite both set: store wins, dm_we=1; out_memData=0.
// - dm_ack outside ACCESS is ignored. dm_req and dm_we are 0 outside ACCESS.
// - Back-to-back memory ops: each op passes through DONE then IDLE, so there is at least one non-stall cycle between them.
// - Reset mid-ACCESS: dm_req drops asynchronously, no capture, FSM returns to IDLE.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - IDLE with access and in_aluResult[1:0]!=0: no dm_req; go straight to DONE (stall 1 cycle).
//   - In DONE: misalign_err=1, out_regWrite=0, out_memData=0.
// - MISALIGN_TRAP_EN undefined: misalign_err tied 0; low address bits silently masked in dm_addr.
// TESTING
// - lw, aluResult=0x10, wreg=8, ack on 2nd ACCESS cycle, rdata=0xCAFEF00D -> stall 3 cycles; WB: out_memData=0xCAFEF00D, out_regWrite=1, out_writeDataReg=8.
// - sw, addr 0x20, data 0x12345678, ack on 1st ACCESS cycle -> dm_req=dm_we=1 for one cycle, dm_wdata=0x12345678; stall 2 cycles; WB out_regWrite=0.
// - Three back-to-back ALU ops (memRead=memWrite=0) -> stall never high; WB updates each cycle with matching aluResult.
// - TIMEOUT_CYC=4, lw, no ack -> dm_req high exactly 4 cycles; bus_err 1-cycle pulse; out_regWrite=0, out_memData=0.
// - rst low during 2nd ACCESS cycle -> dm_req=0 and stall=0 same cycle; after release, FSM is IDLE and all outputs are 0.
// - lw addr 0x13: with MISALIGN_TRAP_EN -> no dm_req, misalign_err pulse, regWrite=0; without it -> dm_addr=0x10.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage controller.
// Drives a req/ack data-memory access for the instruction held in EX/MEM.
// Stalls upstream while the access is in flight and registers MEM/WB outputs.
// Optional feature macro: MISALIGN_TRAP_EN traps word-misaligned accesses
// instead of masking the low address bits.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_memRead,
    input  logic        in_memWrite,
    input  logic [1:0]  in_memToReg,
    input  logic        in_regWrite,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_readData2,
    input  logic [4:0]  in_writeDataReg,
    input  logic [29:0] in_fourPC,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        out_regWrite,
    output logic [1:0]  out_memToReg,
    output logic [31:0] out_aluResult,
    output logic [4:0]  out_writeDataReg,
    output logic [29:0] out_fourPC,
    output logic [31:0] out_memData,
    output logic        bus_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_q, tmo_d;
    logic        mis_q, mis_d;

    logic        stall_c, load_c, done_c, access;

    logic        wb_regWrite_d;
    logic [1:0]  wb_memToReg_d;
    logic [31:0] wb_aluResult_d;
    logic [4:0]  wb_writeDataReg_d;
    logic [29:0] wb_fourPC_d;
    logic [31:0] wb_memData_d;

    assign access   = in_memRead | in_memWrite;
    assign done_c   = (state_q == S_DONE);
    assign dm_addr  = {in_aluResult[31:2], 2'b00};
    assign dm_wdata = in_readData2;
    // Reset is folded in so stall drops the moment rst asserts, even in IDLE.
    assign stall    = rst & stall_c;
    assign bus_err  = done_c & tmo_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err = done_c & mis_q;
`else
    assign misalign_err = 1'b0;
`endif

    // FSM next state, access counter, read-data capture and dmem strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        mis_d   = mis_q;
        stall_c = 1'b0;
        load_c  = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tmo_d = 1'b0;
                mis_d = 1'b0;
                if (access) begin
                    stall_c = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    if (in_aluResult[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else
`endif
                    state_d = S_ACCESS;
                end else begin
                    load_c = 1'b1;
                end
            end
            S_ACCESS: begin
                dm_req  = 1'b1;
                dm_we   = in_memWrite;
                stall_c = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (dm_ack) begin
                    rdata_d = dm_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                load_c  = 1'b1;
                cnt_d   = '0;
                tmo_d   = 1'b0;
                mis_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MEM/WB next values: pass-through on load, bubble otherwise.
    always_comb begin
        wb_regWrite_d     = 1'b0;
        wb_memToReg_d     = '0;
        wb_aluResult_d    = '0;
        wb_writeDataReg_d = '0;
        wb_fourPC_d       = '0;
        wb_memData_d      = '0;
        if (load_c) begin
            wb_regWrite_d     = in_regWrite & ~(done_c & (tmo_q | mis_q));
            wb_memToReg_d     = in_memToReg;
            wb_aluResult_d    = in_aluResult;
            wb_writeDataReg_d = in_writeDataReg;
            wb_fourPC_d       = in_fourPC;
            if (done_c && in_memRead && !in_memWrite && !tmo_q && !mis_q) begin
                wb_memData_d = rdata_q;
            end
        end
    end

    // State, counter, capture buffer and MEM/WB registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            rdata_q          <= '0;
            tmo_q            <= 1'b0;
            mis_q            <= 1'b0;
            out_regWrite     <= 1'b0;
            out_memToReg     <= '0;
            out_aluResult    <= '0;
            out_writeDataReg <= '0;
            out_fourPC       <= '0;
            out_memData      <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            rdata_q          <= rdata_d;
            tmo_q            <= tmo_d;
            mis_q            <= mis_d;
            out_regWrite     <= wb_regWrite_d;
            out_memToReg     <= wb_memToReg_d;
            out_aluResult    <= wb_aluResult_d;
            out_writeDataReg <= wb_writeDataReg_d;
            out_fourPC       <= wb_fourPC_d;
            out_memData      <= wb_memData_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: transaction-level reference model, random ops.
module tb_mem_stage_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk, rst;
    logic        in_memRead, in_memWrite, in_regWrite;
    logic [1:0]  in_memToReg;
    logic [31:0] in_aluResult, in_readData2;
    logic [4:0]  in_writeDataReg;
    logic [29:0] in_fourPC;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall, out_regWrite, bus_err, misalign_err;
    logic [1:0]  out_memToReg;
    logic [31:0] out_aluResult, out_memData;
    logic [4:0]  out_writeDataReg;
    logic [29:0] out_fourPC;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    mem_stage_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_memRead(in_memRead), .in_memWrite(in_memWrite),
        .in_memToReg(in_memToReg), .in_regWrite(in_regWrite),
        .in_aluResult(in_aluResult), .in_readData2(in_readData2),
        .in_writeDataReg(in_writeDataReg), .in_fourPC(in_fourPC),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
        .out_regWrite(out_regWrite), .out_memToReg(out_memToReg),
        .out_aluResult(out_aluResult), .out_writeDataReg(out_writeDataReg),
        .out_fourPC(out_fourPC), .out_memData(out_memData),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        in_memRead = 0; in_memWrite = 0; in_regWrite = 0; in_memToReg = '0;
        in_aluResult = '0; in_readData2 = '0; in_writeDataReg = '0; in_fourPC = '0;
        dm_ack = 0; dm_rdata = '0;
    endtask

    // Called at posedge+1 with the FSM idle; returns at posedge+1 after writeback.
    // ack_k = ACCESS cycle carrying the ack (0 = never acknowledge).
    task automatic run_op(input logic rd, input logic wr, input logic rw,
                          input logic [1:0] m2r, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] wreg,
                          input logic [29:0] fpc, input int unsigned ack_k,
                          input logic [31:0] rdata, input string tag);
        logic access, trap, tmo, e_rw, fin, saw_stall;
        logic [31:0] e_md, e_addr;
        int unsigned e_req, e_stall, n_req, n_st;
        // reference model
        access = rd | wr;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = access && (alu[1:0] != 2'b00);
`endif
        tmo     = access && !trap && (ack_k == 0 || ack_k > TMO);
        e_req   = (!access || trap) ? 0 : (tmo ? TMO : ack_k);
        e_stall = !access ? 0 : (trap ? 1 : e_req + 1);
        e_rw    = rw && !tmo && !trap;
        e_md    = (rd && !wr && !tmo && !trap) ? rdata : 32'h0;
        e_addr  = alu & 32'hFFFF_FFFC;
        // stimulus
        in_memRead = rd; in_memWrite = wr; in_regWrite = rw; in_memToReg = m2r;
        in_aluResult = alu; in_readData2 = wd; in_writeDataReg = wreg; in_fourPC = fpc;
        n_req = 0; n_st = 0; fin = 0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            #1;
            if (dm_req) begin
                n_req++;
                n_cmp++;
                if (dm_we !== wr || dm_addr !== e_addr || dm_wdata !== wd) begin
                    n_bad++;
                    $display("FAIL %s bus: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                             tag, dm_we, dm_addr, dm_wdata, wr, e_addr, wd);
                end
                dm_ack   = (n_req == ack_k);
                dm_rdata = dm_ack ? rdata : $urandom;
            end else begin
                // stray acks outside ACCESS must be ignored
                dm_ack   = 1'($urandom_range(0, 1));
                dm_rdata = $urandom;
                n_cmp++;
                if (dm_we !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s we_idle: got %b want 0", tag, dm_we);
                end
            end
            saw_stall = stall;
            if (stall) begin
                n_st++;
                n_cmp++;
                if (bus_err !== 1'b0 || misalign_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s err_in_stall: got bus=%b mis=%b want 0 0", tag, bus_err, misalign_err);
                end
            end else begin
                fin = 1;
                n_cmp++;
                if (bus_err !== tmo || misalign_err !== trap) begin
                    n_bad++;
                    $display("FAIL %s err_pulse: got bus=%b mis=%b want %b %b", tag, bus_err, misalign_err, tmo, trap);
                end
            end
            @(posedge clk);
            #1;
            dm_ack = 0;
            if (saw_stall) begin
                n_cmp++;
                if (out_regWrite !== 1'b0 || out_aluResult !== 32'h0 || out_fourPC !== 30'h0) begin
                    n_bad++;
                    $display("FAIL %s bubble: got rw=%b alu=%h want 0 0", tag, out_regWrite, out_aluResult);
                end
            end
        end
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL %s completion: got none within 300 cycles want done", tag);
        end
        n_cmp++;
        if (n_st !== e_stall || n_req !== e_req) begin
            n_bad++;
            $display("FAIL %s latency: got stall=%0d req=%0d want stall=%0d req=%0d", tag, n_st, n_req, e_stall, e_req);
        end
        n_cmp++;
        if (out_regWrite !== e_rw || out_memToReg !== m2r || out_aluResult !== alu ||
            out_writeDataReg !== wreg || out_fourPC !== fpc) begin
            n_bad++;
            $display("FAIL %s wb: got rw=%b m2r=%0d alu=%h rd=%0d pc=%h want rw=%b m2r=%0d alu=%h rd=%0d pc=%h",
                     tag, out_regWrite, out_memToReg, out_aluResult, out_writeDataReg, out_fourPC,
                     e_rw, m2r, alu, wreg, fpc);
        end
        if (access) begin
            n_cmp++;
            if (out_memData !== e_md) begin
                n_bad++;
                $display("FAIL %s memdata: got %h want %h", tag, out_memData, e_md);
            end
        end
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        #1;
        n_cmp++;
        if (stall !== 0 || dm_req !== 0 || out_regWrite !== 0 || out_memData !== 0 ||
            out_aluResult !== 0 || out_fourPC !== 0 || bus_err !== 0 || misalign_err !== 0) begin
            n_bad++;
            $display("FAIL reset_state: got stall=%b req=%b rw=%b md=%h want all 0", stall, dm_req, out_regWrite, out_memData);
        end
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_load();
        run_op(1, 0, 1, 2'd1, 32'h10, 32'h0, 5'd8, 30'h100, 2, 32'hCAFEF00D, "lw");
    endtask

    task automatic test_store();
        run_op(0, 1, 0, 2'd0, 32'h20, 32'h12345678, 5'd0, 30'h101, 1, 32'h0, "sw");
    endtask

    task automatic test_back_to_back();
        run_op(0, 0, 1, 2'd0, 32'h1111, 32'h0, 5'd1, 30'h200, 0, 32'h0, "alu0");
        run_op(0, 0, 1, 2'd0, 32'h2222, 32'h0, 5'd2, 30'h201, 0, 32'h0, "alu1");
        run_op(0, 0, 1, 2'd2, 32'h3333, 32'h0, 5'd3, 30'h202, 0, 32'h0, "alu2");
        run_op(1, 0, 1, 2'd1, 32'h40, 32'h0, 5'd4, 30'h203, 1, 32'hA5A5A5A5, "lw_b2b0");
        run_op(1, 0, 1, 2'd1, 32'h44, 32'h0, 5'd5, 30'h204, 3, 32'h5A5A5A5A, "lw_b2b1");
    endtask

    task automatic test_timeout();
        run_op(1, 0, 1, 2'd1, 32'h80, 32'h0, 5'd9, 30'h300, 0, 32'hDEADBEEF, "lw_timeout");
        run_op(1, 0, 1, 2'd1, 32'h84, 32'h0, 5'd9, 30'h301, TMO, 32'h0BADF00D, "lw_last_cycle");
        run_op(1, 1, 1, 2'd1, 32'h88, 32'h77, 5'd9, 30'h302, 2, 32'hFFFFFFFF, "rd_wr_both");
    endtask

    task automatic test_misalign();
        run_op(1, 0, 1, 2'd1, 32'h13, 32'h0, 5'd7, 30'h400, 1, 32'h13131313, "lw_misaligned");
    endtask

    task automatic test_reset_mid_access();
        in_memRead = 1; in_regWrite = 1; in_aluResult = 32'h50; in_writeDataReg = 5'd6;
        dm_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (dm_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: got req=%b want 1", dm_req);
        end
        rst = 0;
        #1;
        n_cmp++;
        if (dm_req !== 0 || stall !== 0 || out_regWrite !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_async: got req=%b stall=%b rw=%b want 0 0 0", dm_req, stall, out_regWrite);
        end
        clear_inputs();
        @(posedge clk); #1;
        rst = 1;
        #1;
        n_cmp++;
        if (dm_req !== 0 || stall !== 0 || out_regWrite !== 0 || out_memData !== 0 ||
            out_aluResult !== 0 || out_writeDataReg !== 0 || bus_err !== 0 || misalign_err !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_release: got req=%b stall=%b md=%h alu=%h want all 0",
                     dm_req, stall, out_memData, out_aluResult);
        end
        @(posedge clk); #1;
        run_op(0, 0, 1, 2'd0, 32'h99, 32'h0, 5'd3, 30'h500, 0, 32'h0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   30'($urandom), $urandom_range(0, TMO + 2), $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_misalign();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
